mulacc: RTL and testbench

Sequential multiply-accumulate unit computing prod = a*b + c, the inverse of the divider. Given a quotient, divisor and remainder, it reconstructs the numerator. The prime generator uses it to cross-check divider results, and it can also serve as a standalone multiplier (c = 0). It uses the same go/ready/error handshake as the divider, so the two share control glue. Operands are WIDTH = 2^WIDTH_LOG bits unsigned, and iteration is shift-and-add over the multiplier bits.

---
 rtl/mulacc.sv | 94 +++++++++
 tb/tb_mulacc.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mulacc.sv
// Sequential shift-and-add multiply-accumulate: prod = a*b + c, one multiplier bit per cycle.
// Define MULACC_SAT_EN to saturate prod to all-ones on overflow instead of wrapping.
module mulacc #(
  parameter int unsigned WIDTH_LOG = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        go_i,
  input  logic [(1 << WIDTH_LOG)-1:0] a_i,
  input  logic [(1 << WIDTH_LOG)-1:0] b_i,
  input  logic [(1 << WIDTH_LOG)-1:0] c_i,
  output logic                        ready_o,
  output logic                        error_o,
  output logic [(1 << WIDTH_LOG)-1:0] prod_o
);

  localparam int unsigned Width = 1 << WIDTH_LOG;

  typedef enum logic [1:0] {StReady, StAdd, StError} state_e;

  state_e             state_q;
  logic [2*Width-1:0] acc_q, acc_d;
  logic [2*Width-1:0] mcand_q;
  logic [Width-1:0]   mplier_q, mplier_d;
  logic [Width-1:0]   prod_q, fin_prod;
  logic               ready_q, error_q;
  logic               done, ovf;

  always_comb begin
    acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
    mplier_d = mplier_q >> 1;
    done     = (mplier_d == '0);
    ovf      = |acc_d[2*Width-1:Width];
`ifdef MULACC_SAT_EN
    fin_prod = ovf ? {Width{1'b1}} : acc_d[Width-1:0];
`else
    fin_prod = acc_d[Width-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StReady;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      ready_q  <= 1'b1;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        StReady, StError: begin
          if (go_i) begin
            // A zero multiplier needs no iteration: the result is just the addend.
            if (b_i == '0) begin
              state_q <= StReady;
              prod_q  <= c_i;
              ready_q <= 1'b1;
              error_q <= 1'b0;
            end else begin
              acc_q    <= {{Width{1'b0}}, c_i};
              mcand_q  <= {{Width{1'b0}}, a_i};
              mplier_q <= b_i;
              state_q  <= StAdd;
              ready_q  <= 1'b0;
              error_q  <= 1'b0;
            end
          end
        end
        StAdd: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_d;
          if (done) begin
            state_q <= ovf ? StError : StReady;
            ready_q <= 1'b1;
            error_q <= ovf;
            prod_q  <= fin_prod;
          end
        end
        default: begin
          state_q <= StReady;
          ready_q <= 1'b1;
          error_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign error_o = error_q;
  assign prod_o  = prod_q;

endmodule

// File: tb/tb_mulacc.sv
// Directed bench for mulacc at WIDTH_LOG=4: vector table plus reset, go-while-busy and
// divider round-trip sequences.
module tb_mulacc;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [15:0] a, b, c;
  logic        ready, error;
  logic [15:0] prod;

  int n_vec = 0;
  int n_bad = 0;

`ifdef MULACC_SAT_EN
  localparam logic [15:0] OvfProd = 16'hFFFF;
`else
  localparam logic [15:0] OvfProd = 16'h0000;
`endif

  mulacc #(.WIDTH_LOG(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .go_i   (go),
    .a_i    (a),
    .b_i    (b),
    .c_i    (c),
    .ready_o(ready),
    .error_o(error),
    .prod_o (prod)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] prod;
    logic        err;
    int          cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue go in the current cycle; count cycles until ready returns (bounded).
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic [15:0] tc,
                        output int cyc);
    @(negedge clk);
    go = 1'b1;
    a  = ta;
    b  = tb;
    c  = tc;
    @(posedge clk);
    #1;
    go  = 1'b0;
    a   = 16'($urandom);
    b   = 16'($urandom);
    c   = 16'($urandom);
    cyc = 0;
    while (!ready && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    int          cyc;
    logic [15:0] num, den, quot, rem;

    vecs[0] = '{16'd6,    16'd7,    16'd5,    16'd47,   1'b0, 3};
    vecs[1] = '{16'h1234, 16'h0000, 16'h00AB, 16'h00AB, 1'b0, 0};
    vecs[2] = '{16'h0100, 16'h0100, 16'h0000, OvfProd,  1'b1, 9};
    vecs[3] = '{16'd2,    16'd3,    16'd1,    16'd7,    1'b0, 2};
    vecs[4] = '{16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 1};
    vecs[5] = '{16'hFFFF, 16'h0001, 16'h0001, OvfProd,  1'b1, 1};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, OvfProd,  1'b1, 16};
    vecs[7] = '{16'h1234, 16'h0000, 16'h0005, 16'h0005, 1'b0, 0};
    vecs[8] = '{16'h00FF, 16'h0100, 16'h00FF, 16'hFFFF, 1'b0, 9};
    vecs[9] = '{16'd123,  16'd45,   16'd67,   16'h15E2, 1'b0, 6};

    rst = 1'b1;
    go  = 1'b0;
    a   = '0;
    b   = '0;
    c   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_prod", 32'(prod), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("idle_hold", {15'd0, ready, error, prod}, {15'd0, 1'b1, 1'b0, 16'h0000});
    end

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, cyc);
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
      chk($sformatf("v%0d_prod", i), 32'(prod), 32'(vecs[i].prod));
      chk($sformatf("v%0d_error", i), 32'(error), 32'(vecs[i].err));
    end

    // go pulses while busy must be ignored and prod must hold the previous result.
    @(negedge clk);
    go = 1'b1;
    a  = 16'd1;
    b  = 16'h8000;
    c  = 16'd0;
    @(posedge clk);
    #1;
    go = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("busy_ready", 32'(ready), 32'd0);
      chk("busy_prod_hold", 32'(prod), 32'(vecs[9].prod));
      go = 1'b1;
      a  = 16'd5;
      b  = 16'd1;
      c  = 16'd0;
      @(posedge clk);
      #1;
      go = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("busy_done_ready", 32'(ready), 32'd1);
    chk("busy_done_prod", 32'(prod), 32'h8000);
    chk("busy_done_error", 32'(error), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", {15'd0, ready, error, prod}, {15'd0, 1'b1, 1'b0, 16'h8000});

    // Reset mid-operation aborts it.
    @(negedge clk);
    go = 1'b1;
    a  = 16'd6;
    b  = 16'd7;
    c  = 16'd5;
    @(posedge clk);
    #1;
    go = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst", {15'd0, ready, error, prod}, {15'd0, 1'b1, 1'b0, 16'h0000});

    // go together with rst: rst wins, nothing is started.
    @(negedge clk);
    go = 1'b1;
    a  = 16'd3;
    b  = 16'd1;
    c  = 16'd4;
    @(posedge clk);
    #1;
    rst = 1'b0;
    go  = 1'b0;
    chk("gorst", {15'd0, ready, error, prod}, {15'd0, 1'b1, 1'b0, 16'h0000});
    repeat (2) @(posedge clk);
    #1;
    chk("gorst_after", {15'd0, ready, error, prod}, {15'd0, 1'b1, 1'b0, 16'h0000});

    // Divider round trip: quot*den + rem reconstructs num.
    for (int i = 0; i < 8; i++) begin
      num  = 16'($urandom);
      den  = 16'($urandom_range(1, 65535));
      if (i == 0) den = 16'd1;
      if (i == 1) den = 16'hFFFF;
      quot = num / den;
      rem  = num % den;
      run_op(quot, den, rem, cyc);
      chk($sformatf("rt%0d_done", i), 32'(ready), 32'd1);
      chk($sformatf("rt%0d_prod", i), 32'(prod), 32'(num));
      chk($sformatf("rt%0d_error", i), 32'(error), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
